ring_inject_stage: RTL and testbench
====================================

// Module: ring_inject_stage
// PURPOSE
//  Ring stop stage directly upstream of clockBoundary: consumes the ring flit arriving at a node,
//  ejects flits addressed to this node and injects local flits into free slots. Drives the
//  128-bit control word that clockBoundary takes as its port0_ci. Bufferless ring: a through
//  flit is never stalled. Local injection is buffered in a small FIFO with valid/ready.
// PARAMETERS
//  NODE_ID     0   4-bit ring address of this node
//  FIFO_DEPTH  4   injection FIFO entries, power of 2, >=2
//  STARVE_LIM  16  consecutive blocked-injection cycles before starve is raised
// PORTS
//  clk          in   1    single clock domain
//  rst          in   1    asynchronous, active-low reset (0 = reset)
//  port0_ci     in   128  incoming ring control word (flit)
//  port0_co     out  128  outgoing ring flit, registered; feeds clockBoundary port0_ci
//  inj_flit     in   128  local flit to inject; valid bit is ignored and forced to 1
//  inj_valid    in   1    inj_flit is presented
//  inj_ready    out  1    FIFO not full; push happens when inj_valid & inj_ready
//  ej_flit      out  128  ejected flit, registered
//  ej_valid     out  1    ej_flit holds a flit for one cycle
//  ej_ready     in   1    local sink can accept an ejection in this cycle
//  starve       out  1    injection starved (see below)
// BEHAVIOUR
//  Flit format: [127] valid, [126:123] dest, [122:119] src, [118:0] payload.
//  Reset (rst=0, async): port0_co=0, ej_flit=0, ej_valid=0, starve=0, FIFO empty,
//   inj_ready=0 while in reset, 1 from the first clock edge after deassertion.
//  Each edge, with in=port0_ci:
//   1. eject = in[127] & dest==NODE_ID & ej_ready. On eject: ej_flit<=in, ej_valid<=1; else ej_valid<=0
//      and ej_flit holds its value.
//   2. A valid flit for this node with ej_ready=0 is deflected: it passes through unchanged and
//      circles the ring.
//   3. Slot free = !in[127] | eject. If free and the FIFO is nonempty: port0_co<=head with [127]=1,
//      [122:119]=NODE_ID, and the FIFO pops. If free and the FIFO is empty: port0_co<=0.
//      Otherwise port0_co<=in (pass-through).
//  Latency: one cycle from port0_ci to port0_co/ej_flit. Latency from FIFO head to port0_co is
//   one cycle when a slot is free.
//  FIFO: circular, with rd/wr pointers of log2(FIFO_DEPTH)+1 bits. Wrap-around uses the MSB.
//   full = (ptr MSBs differ & low bits equal). inj_ready = !full. A simultaneous push and pop
//   when full is not allowed, because the push is blocked by inj_ready. A simultaneous push and
//   pop when empty is allowed; the pushed flit becomes the head at the next edge and is not
//   bypassed.
//  Starve counter: increments when FIFO nonempty & no free slot, saturating at STARVE_LIM. It
//   clears to 0 on any pop or when the FIFO is empty. starve = (count==STARVE_LIM), registered.
//  A self-addressed injected flit (dest==NODE_ID) travels the full ring and then ejects normally.
//  Reset mid-operation: FIFO contents, in-flight port0_co and ej_flit are discarded at once.
// STRUCTURE
//  Shared package/defines.v: `control_w (128), FLIT_VALID_BIT=127, DEST_LSB/MSB, SRC_LSB/MSB,
//   NODE_W=4.
//  One sub-module: ring_inj_fifo (param WIDTH, DEPTH; push/pop/head/full/empty). All other logic
//   is inline in ring_inject_stage.
// TESTING
//  Reset: hold rst=0 and then release -> port0_co=0, ej_valid=0, inj_ready=1 after the first edge.
//  Pass-through: NODE_ID=0, port0_ci={1,dest=3,...} -> same 128-bit word on port0_co one cycle
//   later, ej_valid=0.
//  Eject plus inject into the freed slot: FIFO holds A, port0_ci dest=0, ej_ready=1 -> ej_flit=in,
//   ej_valid=1, and port0_co=A with [127]=1 and src=0 in the same cycle.
//  Deflect: dest=0, ej_ready=0 -> flit appears on port0_co unchanged, ej_valid=0, FIFO does not pop.
//  FIFO full/wrap: push 4 with the ring saturated -> inj_ready=0. Then free 6 slots with a push
//   alongside -> flits leave in order, with pointers wrapping correctly.
//  Starvation: FIFO nonempty and 16 valid through-flits -> starve=1 at cycle 16. It clears on the
//   first pop after that.

Source files
------------

// File: rtl/ring_inject_stage_pkg.sv
// Shared flit layout for the ring stop stage: field positions, node address width
// and small helpers for reading and stamping flits.
package ring_inject_stage_pkg;

    localparam int CONTROL_W      = 128;
    localparam int FLIT_VALID_BIT = 127;
    localparam int DEST_MSB       = 126;
    localparam int DEST_LSB       = 123;
    localparam int SRC_MSB        = 122;
    localparam int SRC_LSB        = 119;
    localparam int NODE_W         = 4;

    typedef logic [CONTROL_W-1:0] flit_t;
    typedef logic [NODE_W-1:0]    node_t;

    // Destination field of a flit.
    function automatic node_t flit_dest(input flit_t f);
        return f[DEST_MSB:DEST_LSB];
    endfunction

    // A locally injected flit always goes out valid and carries this node as source.
    function automatic flit_t stamp_inject(input flit_t f, input node_t src);
        flit_t r;
        r                   = f;
        r[FLIT_VALID_BIT]   = 1'b1;
        r[SRC_MSB:SRC_LSB]  = src;
        return r;
    endfunction

endpackage

// File: rtl/ring_inj_fifo.sv
// Circular injection FIFO. Pointers carry one extra wrap bit so full and empty
// are distinguishable without a separate count. Storage is not reset; only the
// pointers are, which empties the FIFO at once.
module ring_inj_fifo #(
    parameter int WIDTH = 128,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push_i,
    input  logic [WIDTH-1:0] wdata_i,
    input  logic             pop_i,
    output logic [WIDTH-1:0] head_o,
    output logic             full_o,
    output logic             empty_o
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] PTR_ONE = {{AW{1'b0}}, 1'b1};

    logic [AW:0]      wr_ptr_q, wr_ptr_d;
    logic [AW:0]      rd_ptr_q, rd_ptr_d;
    logic [WIDTH-1:0] mem_q [DEPTH];
    logic             do_push, do_pop;

    assign full_o  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                     (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign empty_o = (wr_ptr_q == rd_ptr_q);
    assign head_o  = mem_q[rd_ptr_q[AW-1:0]];

    // Guard push/pop against full/empty so a bad request can never corrupt the pointers.
    assign do_push = push_i && !full_o;
    assign do_pop  = pop_i && !empty_o;

    // Next pointer values.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (do_push) wr_ptr_d = wr_ptr_q + PTR_ONE;
        if (do_pop)  rd_ptr_d = rd_ptr_q + PTR_ONE;
    end

    // Pointer registers; reset empties the FIFO.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    // Entry storage; written at the write pointer on an accepted push.
    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q[AW-1:0]] <= wdata_i;
    end

endmodule

// File: rtl/ring_inject_stage.sv
// Bufferless ring stop: ejects flits addressed to this node, deflects them when the
// local sink is busy, and injects buffered local flits into free slots. Output feeds
// the downstream clock boundary as its control word.
module ring_inject_stage
    import ring_inject_stage_pkg::*;
#(
    parameter logic [NODE_W-1:0] NODE_ID    = '0,
    parameter int                FIFO_DEPTH = 4,
    parameter int                STARVE_LIM = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [CONTROL_W-1:0] port0_ci,
    output logic [CONTROL_W-1:0] port0_co,
    input  logic [CONTROL_W-1:0] inj_flit,
    input  logic                 inj_valid,
    output logic                 inj_ready,
    output logic [CONTROL_W-1:0] ej_flit,
    output logic                 ej_valid,
    input  logic                 ej_ready,
    output logic                 starve
);

    localparam int                CNT_W   = $clog2(STARVE_LIM + 1);
    localparam logic [CNT_W-1:0]  CNT_LIM = CNT_W'(STARVE_LIM);
    localparam logic [CNT_W-1:0]  CNT_ONE = CNT_W'(1);

    flit_t            port0_co_q, port0_co_d;
    flit_t            ej_flit_q, ej_flit_d;
    logic             ej_valid_q, ej_valid_d;
    logic             live_q;
    logic [CNT_W-1:0] starve_cnt_q, starve_cnt_d;
    logic             starve_q, starve_d;

    flit_t            fifo_head;
    logic             fifo_full, fifo_empty;
    logic             in_valid, eject, slot_free, pop, push;

    // inj_ready stays low during reset and rises on the first edge afterwards.
    assign inj_ready = live_q && !fifo_full;
    assign push      = inj_valid && inj_ready;

    assign in_valid  = port0_ci[FLIT_VALID_BIT];
    assign eject     = in_valid && (flit_dest(port0_ci) == NODE_ID) && ej_ready;
    assign slot_free = !in_valid || eject;
    assign pop       = slot_free && !fifo_empty;

    ring_inj_fifo #(
        .WIDTH (CONTROL_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (rst),
        .push_i  (push),
        .wdata_i (inj_flit),
        .pop_i   (pop),
        .head_o  (fifo_head),
        .full_o  (fifo_full),
        .empty_o (fifo_empty)
    );

    // Slot arbitration, ejection capture and starvation counting.
    always_comb begin
        port0_co_d   = port0_ci;
        ej_flit_d    = ej_flit_q;
        ej_valid_d   = eject;
        starve_cnt_d = starve_cnt_q;

        if (eject) ej_flit_d = port0_ci;

        // A deflected flit (for us, sink busy) is not free, so it falls through unchanged.
        if (slot_free) begin
            if (!fifo_empty) port0_co_d = stamp_inject(fifo_head, NODE_ID);
            else             port0_co_d = '0;
        end

        if (pop || fifo_empty) begin
            starve_cnt_d = '0;
        end else if (!slot_free && (starve_cnt_q != CNT_LIM)) begin
            starve_cnt_d = starve_cnt_q + CNT_ONE;
        end

        starve_d = (starve_cnt_d == CNT_LIM);
    end

    // Stage registers; reset discards in-flight ring and ejection flits immediately.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            port0_co_q   <= '0;
            ej_flit_q    <= '0;
            ej_valid_q   <= 1'b0;
            live_q       <= 1'b0;
            starve_cnt_q <= '0;
            starve_q     <= 1'b0;
        end else begin
            port0_co_q   <= port0_co_d;
            ej_flit_q    <= ej_flit_d;
            ej_valid_q   <= ej_valid_d;
            live_q       <= 1'b1;
            starve_cnt_q <= starve_cnt_d;
            starve_q     <= starve_d;
        end
    end

    assign port0_co = port0_co_q;
    assign ej_flit  = ej_flit_q;
    assign ej_valid = ej_valid_q;
    assign starve   = starve_q;

endmodule

// File: tb/tb_ring_inject_stage.sv
// Directed bench for ring_inject_stage (NODE_ID=0, FIFO_DEPTH=4, STARVE_LIM=16).
module tb_ring_inject_stage;

    logic         clk = 1'b0;
    logic         rst;
    logic [127:0] port0_ci, port0_co, inj_flit, ej_flit;
    logic         inj_valid, inj_ready, ej_valid, ej_ready, starve;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    ring_inject_stage #(
        .NODE_ID    (4'd0),
        .FIFO_DEPTH (4),
        .STARVE_LIM (16)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .port0_ci  (port0_ci),
        .port0_co  (port0_co),
        .inj_flit  (inj_flit),
        .inj_valid (inj_valid),
        .inj_ready (inj_ready),
        .ej_flit   (ej_flit),
        .ej_valid  (ej_valid),
        .ej_ready  (ej_ready),
        .starve    (starve)
    );

    typedef struct {
        logic [127:0] ci;
        logic         ejr;
        logic [127:0] co;
        logic         ejv;
        logic [127:0] ejf;
    } vec_t;

    function automatic logic [127:0] mk(input logic v, input logic [3:0] d,
                                        input logic [3:0] s, input logic [118:0] p);
        return {v, d, s, p};
    endfunction

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got=%h want=%h", name, act, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    vec_t         tbl [6];
    logic [127:0] P1, P2, P3, P4, P5, P6, A, B, S, T, Tout;
    logic [127:0] F [5];
    logic [127:0] E [5];

    initial begin
        P1 = mk(1'b1, 4'd3,  4'd5, 119'h1111);
        P2 = mk(1'b1, 4'd0,  4'd6, 119'h2222);
        P3 = mk(1'b1, 4'd0,  4'd7, 119'h3333);
        P4 = mk(1'b0, 4'd9,  4'd2, 119'h4444);
        P5 = mk(1'b1, 4'd15, 4'd1, 119'h5555);
        P6 = mk(1'b0, 4'd0,  4'd3, 119'h6666);

        tbl[0] = '{P1, 1'b1, P1,     1'b0, 128'd0};
        tbl[1] = '{P2, 1'b1, 128'd0, 1'b1, P2};
        tbl[2] = '{P3, 1'b0, P3,     1'b0, P2};
        tbl[3] = '{P4, 1'b1, 128'd0, 1'b0, P2};
        tbl[4] = '{P5, 1'b0, P5,     1'b0, P2};
        tbl[5] = '{P6, 1'b1, 128'd0, 1'b0, P2};

        for (int i = 0; i < 5; i++) begin
            F[i] = mk(1'b1, 4'(i + 1), 4'hC, 119'(12'hF00 + i));
            E[i] = mk(1'b1, 4'(i + 1), 4'h0, 119'(12'hF00 + i));
        end

        // Reset
        rst = 1'b0; port0_ci = '0; inj_flit = '0; inj_valid = 1'b0; ej_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_co", port0_co, 128'd0);
        chk("rst_ejv", ej_valid, 1'b0);
        chk("rst_ejf", ej_flit, 128'd0);
        chk("rst_injrdy", inj_ready, 1'b0);
        chk("rst_starve", starve, 1'b0);
        @(negedge clk) rst = 1'b1;
        cyc();
        chk("post_rst_injrdy", inj_ready, 1'b1);
        chk("post_rst_co", port0_co, 128'd0);
        chk("post_rst_ejv", ej_valid, 1'b0);

        // Table: empty FIFO, pass / eject / deflect / idle slots
        for (int i = 0; i < 6; i++) begin
            port0_ci = tbl[i].ci;
            ej_ready = tbl[i].ejr;
            cyc();
            chk($sformatf("vec%0d_co", i), port0_co, tbl[i].co);
            chk($sformatf("vec%0d_ejv", i), ej_valid, tbl[i].ejv);
            chk($sformatf("vec%0d_ejf", i), ej_flit, tbl[i].ejf);
        end

        // Eject plus inject into the freed slot
        A = mk(1'b0, 4'd9, 4'd7, 119'hA0A0);
        inj_flit = A; inj_valid = 1'b1; port0_ci = P1; ej_ready = 1'b1;
        cyc();
        inj_valid = 1'b0;
        chk("ejinj_busy_co", port0_co, P1);
        port0_ci = P2;
        cyc();
        chk("ejinj_ejv", ej_valid, 1'b1);
        chk("ejinj_ejf", ej_flit, P2);
        chk("ejinj_co", port0_co, mk(1'b1, 4'd9, 4'd0, 119'hA0A0));

        // Deflect with a queued flit: no pop until a real free slot
        B = mk(1'b1, 4'd2, 4'd5, 119'hB0B0);
        inj_flit = B; inj_valid = 1'b1; port0_ci = P5;
        cyc();
        inj_valid = 1'b0;
        chk("defl_push_co", port0_co, P5);
        port0_ci = P3; ej_ready = 1'b0;
        cyc();
        chk("defl_co", port0_co, P3);
        chk("defl_ejv", ej_valid, 1'b0);
        port0_ci = '0;
        cyc();
        chk("defl_then_inj_co", port0_co, mk(1'b1, 4'd2, 4'd0, 119'hB0B0));

        // FIFO fill with saturated ring, then drain across the pointer wrap
        port0_ci = P1; ej_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            inj_flit = F[i]; inj_valid = 1'b1;
            cyc();
            chk($sformatf("fill%0d_co", i), port0_co, P1);
        end
        chk("full_injrdy", inj_ready, 1'b0);
        inj_flit = F[4];
        cyc();
        chk("full_hold_injrdy", inj_ready, 1'b0);
        port0_ci = '0;
        cyc();
        chk("drain0_co", port0_co, E[0]);
        chk("drain0_injrdy", inj_ready, 1'b1);
        cyc();
        inj_valid = 1'b0;
        chk("drain1_co", port0_co, E[1]);
        for (int i = 2; i < 5; i++) begin
            cyc();
            chk($sformatf("drain%0d_co", i), port0_co, E[i]);
        end
        cyc();
        chk("drain_empty_co", port0_co, 128'd0);

        // Starvation
        S = mk(1'b1, 4'd5, 4'd3, 119'h5A5A);
        inj_flit = S; inj_valid = 1'b1; port0_ci = P1;
        cyc();
        inj_valid = 1'b0;
        for (int k = 1; k <= 16; k++) begin
            cyc();
            if (k == 15) chk("starve_at15", starve, 1'b0);
            if (k == 16) chk("starve_at16", starve, 1'b1);
        end
        cyc();
        chk("starve_sat", starve, 1'b1);
        port0_ci = '0;
        cyc();
        chk("starve_pop_co", port0_co, mk(1'b1, 4'd5, 4'd0, 119'h5A5A));
        chk("starve_clear", starve, 1'b0);

        // Self-addressed injected flit returns and ejects
        T = mk(1'b1, 4'd0, 4'd9, 119'h7777);
        Tout = mk(1'b1, 4'd0, 4'd0, 119'h7777);
        inj_flit = T; inj_valid = 1'b1; port0_ci = P1;
        cyc();
        inj_valid = 1'b0; port0_ci = '0;
        cyc();
        chk("self_inj_co", port0_co, Tout);
        port0_ci = Tout; ej_ready = 1'b1;
        cyc();
        chk("self_ejv", ej_valid, 1'b1);
        chk("self_ejf", ej_flit, Tout);
        chk("self_co", port0_co, 128'd0);

        // Reset mid-operation
        inj_flit = mk(1'b1, 4'd3, 4'd0, 119'h9999); inj_valid = 1'b1; port0_ci = P1;
        repeat (2) cyc();
        inj_valid = 1'b0; port0_ci = P2; ej_ready = 1'b1;
        cyc();
        chk("midrst_pre_ejv", ej_valid, 1'b1);
        #2 rst = 1'b0;
        #1;
        chk("midrst_co", port0_co, 128'd0);
        chk("midrst_ejf", ej_flit, 128'd0);
        chk("midrst_ejv", ej_valid, 1'b0);
        chk("midrst_injrdy", inj_ready, 1'b0);
        port0_ci = '0;
        @(negedge clk) rst = 1'b1;
        cyc();
        chk("midrst_fifo_flushed", port0_co, 128'd0);
        chk("midrst_after_injrdy", inj_ready, 1'b1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
